// File: rtl/decode_queue_if.sv
//------------------------------------------------------------------------------
// Module      : decode_queue_if
// Description : Handshake bundle between fetch, decode queue and execute.
//               The slave side is the queue; the master side is its
//               fetch/execute environment.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface decode_queue_if #(
  parameter int ROM_W = 6
) ();
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [31:0]      in_pc;
  logic             out_valid;
  logic             out_ready;
  logic [ROM_W-1:0] out_code;
  logic [31:0]      out_pc;
  logic [4:0]       out_rd;
  logic [4:0]       out_rs1;
  logic [4:0]       out_rs2;
  logic [31:0]      out_imm;
  logic             out_rd_we;
  logic             out_illegal;

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_code, out_pc, out_rd, out_rs1, out_rs2,
           out_imm, out_rd_we, out_illegal
  );

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_code, out_pc, out_rd, out_rs1, out_rs2,
           out_imm, out_rd_we, out_illegal
  );
endinterface

`default_nettype wire

// File: rtl/decode_queue.sv
//------------------------------------------------------------------------------
// Module      : decode_queue
// Description : RV32I (+CSRRW/CSRRWI) decoder feeding a small FIFO of decoded
//               entries. Instructions are decoded on enqueue; the head entry
//               drives the outputs directly from storage.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module decode_queue #(
  parameter int DEPTH  = 2,
  parameter int ROM_W  = 6,
  parameter int EN_CSR = 1
) (
  input  wire logic        clk,
  input  wire logic        rst,
  decode_queue_if.slave    q
);

  localparam int c_PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_CW = $clog2(DEPTH + 1);
  localparam logic [c_PW-1:0] c_LAST  = c_PW'(DEPTH - 1);
  localparam logic [c_CW-1:0] c_FULL  = c_CW'(DEPTH);

  localparam logic [6:0] c_OP_R      = 7'b0110011;
  localparam logic [6:0] c_OP_IMM    = 7'b0010011;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] c_F7_ZERO   = 7'b0000000;
  localparam logic [6:0] c_F7_ALT    = 7'b0100000;

  // Instruction fields
  logic [31:0] w_i;
  logic [6:0]  w_opc;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [4:0]  w_rd;

  assign w_i   = q.in_instr;
  assign w_opc = w_i[6:0];
  assign w_f3  = w_i[14:12];
  assign w_f7  = w_i[31:25];
  assign w_rd  = w_i[11:7];

  // Decode results
  logic             w_ill;
  logic [5:0]       w_op6;
  logic [31:0]      w_imm_raw;
  logic             w_we_raw;
  logic [ROM_W-1:0] w_code;
  logic [31:0]      w_imm;
  logic             w_we;

  // Immediate forms
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm_sh, w_imm_z;
  assign w_imm_i  = {{20{w_i[31]}}, w_i[31:20]};
  assign w_imm_s  = {{20{w_i[31]}}, w_i[31:25], w_i[11:7]};
  assign w_imm_b  = {{19{w_i[31]}}, w_i[31], w_i[7], w_i[30:25], w_i[11:8], 1'b0};
  assign w_imm_u  = {w_i[31:12], 12'b0};
  assign w_imm_j  = {{11{w_i[31]}}, w_i[31], w_i[19:12], w_i[20], w_i[30:21], 1'b0};
  assign w_imm_sh = {27'b0, w_i[24:20]};
  assign w_imm_z  = {27'b0, w_i[19:15]};

  // Combinational decode of the offered instruction into code/imm/write-enable
  always_comb begin
    w_ill     = 1'b0;
    w_op6     = 6'd0;
    w_imm_raw = 32'd0;
    w_we_raw  = 1'b0;
    if (w_i[1:0] != 2'b11) begin
      w_ill = 1'b1;
    end else begin
      case (w_opc)
        c_OP_R: begin
          w_we_raw = 1'b1;
          case (w_f3)
            3'd0: begin
              if (w_f7 == c_F7_ZERO)     w_op6 = 6'd0;  // ADD
              else if (w_f7 == c_F7_ALT) w_op6 = 6'd1;  // SUB
              else                       w_ill = 1'b1;
            end
            3'd5: begin
              if (w_f7 == c_F7_ZERO)     w_op6 = 6'd6;  // SRL
              else if (w_f7 == c_F7_ALT) w_op6 = 6'd7;  // SRA
              else                       w_ill = 1'b1;
            end
            default: begin
              // SLL=2 SLT=3 SLTU=4 XOR=5 OR=8 AND=9
              case (w_f3)
                3'd1:    w_op6 = 6'd2;
                3'd2:    w_op6 = 6'd3;
                3'd3:    w_op6 = 6'd4;
                3'd4:    w_op6 = 6'd5;
                3'd6:    w_op6 = 6'd8;
                default: w_op6 = 6'd9;
              endcase
              if (w_f7 != c_F7_ZERO) w_ill = 1'b1;
            end
          endcase
        end
        c_OP_IMM: begin
          w_we_raw  = 1'b1;
          w_imm_raw = w_imm_i;
          case (w_f3)
            3'd0: w_op6 = 6'd15;                      // ADDI
            3'd1: begin                               // SLLI
              w_op6     = 6'd16;
              w_imm_raw = w_imm_sh;
              if (w_f7 != c_F7_ZERO) w_ill = 1'b1;
            end
            3'd2: w_op6 = 6'd17;                      // SLTI
            3'd3: w_op6 = 6'd18;                      // SLTIU
            3'd4: w_op6 = 6'd19;                      // XORI
            3'd5: begin                               // SRLI / SRAI
              w_imm_raw = w_imm_sh;
              if (w_f7 == c_F7_ZERO)     w_op6 = 6'd20;
              else if (w_f7 == c_F7_ALT) w_op6 = 6'd21;
              else                       w_ill = 1'b1;
            end
            3'd6:    w_op6 = 6'd22;                   // ORI
            default: w_op6 = 6'd23;                   // ANDI
          endcase
        end
        c_OP_LOAD: begin
          w_we_raw  = 1'b1;
          w_imm_raw = w_imm_i;
          case (w_f3)
            3'd0:    w_op6 = 6'd10;                   // LB
            3'd1:    w_op6 = 6'd11;                   // LH
            3'd2:    w_op6 = 6'd12;                   // LW
            3'd4:    w_op6 = 6'd13;                   // LBU
            3'd5:    w_op6 = 6'd14;                   // LHU
            default: w_ill = 1'b1;
          endcase
        end
        c_OP_STORE: begin
          w_imm_raw = w_imm_s;
          case (w_f3)
            3'd0:    w_op6 = 6'd24;                   // SB
            3'd1:    w_op6 = 6'd25;                   // SH
            3'd2:    w_op6 = 6'd26;                   // SW
            default: w_ill = 1'b1;
          endcase
        end
        c_OP_BRANCH: begin
          w_imm_raw = w_imm_b;
          case (w_f3)
            3'd0:    w_op6 = 6'd27;                   // BEQ
            3'd1:    w_op6 = 6'd28;                   // BNE
            3'd4:    w_op6 = 6'd29;                   // BLT
            3'd5:    w_op6 = 6'd30;                   // BGE
            3'd6:    w_op6 = 6'd31;                   // BLTU
            3'd7:    w_op6 = 6'd32;                   // BGEU
            default: w_ill = 1'b1;
          endcase
        end
        c_OP_AUIPC: begin
          w_op6 = 6'd33; w_imm_raw = w_imm_u; w_we_raw = 1'b1;
        end
        c_OP_LUI: begin
          w_op6 = 6'd34; w_imm_raw = w_imm_u; w_we_raw = 1'b1;
        end
        c_OP_JAL: begin
          w_op6 = 6'd35; w_imm_raw = w_imm_j; w_we_raw = 1'b1;
        end
        c_OP_JALR: begin
          w_op6 = 6'd36; w_imm_raw = w_imm_i; w_we_raw = 1'b1;
          if (w_f3 != 3'd0) w_ill = 1'b1;
        end
        c_OP_SYSTEM: begin
          w_we_raw = 1'b1;
          if (EN_CSR == 0) begin
            w_ill = 1'b1;
          end else if (w_f3 == 3'b001) begin
            w_op6 = 6'd37; w_imm_raw = w_imm_i;      // CSRRW: CSR address
          end else if (w_f3 == 3'b101) begin
            w_op6 = 6'd38; w_imm_raw = w_imm_z;      // CSRRWI: uimm
          end else begin
            w_ill = 1'b1;
          end
        end
        default: w_ill = 1'b1;
      endcase
    end
  end

  // Illegal entries carry a canonical payload so downstream sees no stale fields
  assign w_code = w_ill ? {ROM_W{1'b1}} : ROM_W'(w_op6);
  assign w_imm  = w_ill ? 32'd0 : w_imm_raw;
  assign w_we   = !w_ill && w_we_raw && (w_rd != 5'd0);

  // Queue control
  logic [c_PW-1:0] r_wptr, r_rptr;
  logic [c_CW-1:0] r_count;
  logic            w_push, w_pop;

  assign q.in_ready  = (r_count < c_FULL);
  assign q.out_valid = (r_count != '0);
  assign w_push      = q.in_valid && q.in_ready;
  assign w_pop       = q.out_valid && q.out_ready;

  // Pointer/count update; flush beats any concurrent push or pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (q.flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= (r_wptr == c_LAST) ? '0 : r_wptr + 1'b1;
      if (w_pop)  r_rptr <= (r_rptr == c_LAST) ? '0 : r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Decoded payload storage; contents only matter once counted valid
  logic [ROM_W-1:0] r_code [DEPTH];
  logic [31:0]      r_pc   [DEPTH];
  logic [4:0]       r_rd   [DEPTH];
  logic [4:0]       r_rs1  [DEPTH];
  logic [4:0]       r_rs2  [DEPTH];
  logic [31:0]      r_imm  [DEPTH];
  logic             r_we   [DEPTH];
  logic             r_ill  [DEPTH];

  // Write the decoded entry at the tail on an accepted, unflushed push
  always_ff @(posedge clk) begin
    if (w_push && !q.flush) begin
      r_code[r_wptr] <= w_code;
      r_pc[r_wptr]   <= q.in_pc;
      r_rd[r_wptr]   <= w_rd;
      r_rs1[r_wptr]  <= w_i[19:15];
      r_rs2[r_wptr]  <= w_i[24:20];
      r_imm[r_wptr]  <= w_imm;
      r_we[r_wptr]   <= w_we;
      r_ill[r_wptr]  <= w_ill;
    end
  end

  assign q.out_code    = r_code[r_rptr];
  assign q.out_pc      = r_pc[r_rptr];
  assign q.out_rd      = r_rd[r_rptr];
  assign q.out_rs1     = r_rs1[r_rptr];
  assign q.out_rs2     = r_rs2[r_rptr];
  assign q.out_imm     = r_imm[r_rptr];
  assign q.out_rd_we   = r_we[r_rptr];
  assign q.out_illegal = r_ill[r_rptr];

endmodule

`default_nettype wire

// File: tb/tb_decode_queue.sv
//------------------------------------------------------------------------------
// Module      : tb_decode_queue
// Description : Directed self-checking bench for decode_queue (DEPTH=2).
//               Instance A has CSR decode enabled, instance B disabled.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_decode_queue;

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  decode_queue_if #(.ROM_W(6)) qa ();
  decode_queue_if #(.ROM_W(6)) qb ();

  decode_queue #(.DEPTH(2), .ROM_W(6), .EN_CSR(1)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .q   (qa)
  );

  decode_queue #(.DEPTH(2), .ROM_W(6), .EN_CSR(0)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .q   (qb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute time bound on the run
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_a(input logic [31:0] instr, input logic [31:0] pc);
    qa.in_valid = 1'b1;
    qa.in_instr = instr;
    qa.in_pc    = pc;
  endtask

  // Stream table: instr, code, imm, rd_we, illegal
  logic [31:0] t_instr [7];
  logic [5:0]  t_code  [7];
  logic [31:0] t_imm   [7];
  logic        t_we    [7];
  logic        t_ill   [7];

  initial begin
    t_instr[0] = 32'h0000007F; t_code[0] = 6'd63; t_imm[0] = 32'h0;        t_we[0] = 0; t_ill[0] = 1;
    t_instr[1] = 32'h40209033; t_code[1] = 6'd63; t_imm[1] = 32'h0;        t_we[1] = 0; t_ill[1] = 1;
    t_instr[2] = 32'h0000200F; t_code[2] = 6'd63; t_imm[2] = 32'h0;        t_we[2] = 0; t_ill[2] = 1;
    t_instr[3] = 32'h40315093; t_code[3] = 6'd21; t_imm[3] = 32'h3;        t_we[3] = 1; t_ill[3] = 0;
    t_instr[4] = 32'h008000EF; t_code[4] = 6'd35; t_imm[4] = 32'h8;        t_we[4] = 1; t_ill[4] = 0;
    t_instr[5] = 32'h12345137; t_code[5] = 6'd34; t_imm[5] = 32'h12345000; t_we[5] = 1; t_ill[5] = 0;
    t_instr[6] = 32'h0020A423; t_code[6] = 6'd26; t_imm[6] = 32'h8;        t_we[6] = 0; t_ill[6] = 0;
  end

  initial begin
    rst = 1'b1;
    qa.flush = 1'b0; qa.in_valid = 1'b0; qa.in_instr = '0; qa.in_pc = '0; qa.out_ready = 1'b0;
    qb.flush = 1'b0; qb.in_valid = 1'b0; qb.in_instr = '0; qb.in_pc = '0; qb.out_ready = 1'b1;
    #2;
    check("rst_out_valid", qa.out_valid, 1'b0);
    check("rst_in_ready",  qa.in_ready,  1'b1);
    step(); step();
    rst = 1'b0;

    // Single add with consumer ready
    qa.out_ready = 1'b1;
    push_a(32'h002081B3, 32'h100);
    step();
    qa.in_valid = 1'b0;
    check("add_valid", qa.out_valid, 1'b1);
    check("add_code",  qa.out_code,  6'd0);
    check("add_rd",    qa.out_rd,    5'd3);
    check("add_rs1",   qa.out_rs1,   5'd1);
    check("add_rs2",   qa.out_rs2,   5'd2);
    check("add_we",    qa.out_rd_we, 1'b1);
    check("add_pc",    qa.out_pc,    32'h100);
    check("add_imm",   qa.out_imm,   32'h0);
    check("add_ill",   qa.out_illegal, 1'b0);
    step();
    check("add_drained", qa.out_valid, 1'b0);

    // lw, bne, addi with a stalled consumer: fill, hold, drain in order
    qa.out_ready = 1'b0;
    push_a(32'hFFC12083, 32'h200);
    step();
    check("lw_code",  qa.out_code, 6'd12);
    check("lw_imm",   qa.out_imm,  32'hFFFFFFFC);
    check("lw_rd",    qa.out_rd,   5'd1);
    check("one_in_ready", qa.in_ready, 1'b1);
    push_a(32'hFE209EE3, 32'h204);
    step();
    check("full_in_ready", qa.in_ready, 1'b0);
    check("full_head", qa.out_code, 6'd12);
    push_a(32'h00700293, 32'h208);
    step();
    check("held_in_ready", qa.in_ready, 1'b0);
    check("held_head_code", qa.out_code, 6'd12);
    check("held_head_pc",   qa.out_pc,   32'h200);
    qa.out_ready = 1'b1;
    step();
    check("bne_code", qa.out_code,  6'd28);
    check("bne_imm",  qa.out_imm,   32'hFFFFFFFC);
    check("bne_we",   qa.out_rd_we, 1'b0);
    check("bne_pc",   qa.out_pc,    32'h204);
    check("bne_in_ready", qa.in_ready, 1'b1);
    step();
    qa.in_valid = 1'b0;
    check("addi_code", qa.out_code,  6'd15);
    check("addi_rd",   qa.out_rd,    5'd5);
    check("addi_imm",  qa.out_imm,   32'h7);
    check("addi_we",   qa.out_rd_we, 1'b1);
    check("addi_pc",   qa.out_pc,    32'h208);
    step();
    check("drain_empty", qa.out_valid, 1'b0);

    // Back-to-back stream of illegal and assorted legal encodings
    for (int k = 0; k < 7; k++) begin
      push_a(t_instr[k], 32'h300 + 32'(4 * k));
      step();
      check("stream_valid", qa.out_valid,   1'b1);
      check("stream_code",  qa.out_code,    t_code[k]);
      check("stream_imm",   qa.out_imm,     t_imm[k]);
      check("stream_we",    qa.out_rd_we,   t_we[k]);
      check("stream_ill",   qa.out_illegal, t_ill[k]);
      check("stream_pc",    qa.out_pc,      32'h300 + 32'(4 * k));
    end
    qa.in_valid = 1'b0;
    step();
    check("stream_empty", qa.out_valid, 1'b0);

    // Flush with one entry, concurrent push and pop both dropped
    qa.out_ready = 1'b0;
    push_a(32'h00700293, 32'h400);
    step();
    qa.flush = 1'b1; qa.out_ready = 1'b1;
    push_a(32'h002081B3, 32'h404);
    step();
    qa.flush = 1'b0; qa.in_valid = 1'b0;
    check("flush1_valid", qa.out_valid, 1'b0);
    check("flush1_ready", qa.in_ready,  1'b1);
    step();
    check("flush1_nopush", qa.out_valid, 1'b0);

    // Flush with a full queue and the source still offering
    qa.out_ready = 1'b0;
    push_a(32'h00700293, 32'h500); step();
    push_a(32'h12345137, 32'h504); step();
    check("prefl_full", qa.in_ready, 1'b0);
    qa.flush = 1'b1;
    push_a(32'h0020A423, 32'h508);
    step();
    qa.flush = 1'b0; qa.in_valid = 1'b0;
    check("flush2_valid", qa.out_valid, 1'b0);
    check("flush2_ready", qa.in_ready,  1'b1);
    push_a(32'h002081B3, 32'h600);
    step();
    qa.in_valid = 1'b0;
    check("postfl_code", qa.out_code, 6'd0);
    check("postfl_pc",   qa.out_pc,   32'h600);
    qa.out_ready = 1'b1;
    step();
    check("postfl_single", qa.out_valid, 1'b0);

    // CSR decode enabled (A) versus disabled (B)
    push_a(32'h34011073, 32'h700);
    qb.in_valid = 1'b1; qb.in_instr = 32'h34011073; qb.in_pc = 32'h700;
    step();
    check("csrrw_code",  qa.out_code,    6'd37);
    check("csrrw_rs1",   qa.out_rs1,     5'd2);
    check("csrrw_ill",   qa.out_illegal, 1'b0);
    check("csrrw_we",    qa.out_rd_we,   1'b0);
    check("nocsr_ill",   qb.out_illegal, 1'b1);
    check("nocsr_code",  qb.out_code,    6'd63);
    push_a(32'h3402D0F3, 32'h704);
    qb.in_valid = 1'b0;
    step();
    qa.in_valid = 1'b0;
    check("csrrwi_code", qa.out_code,  6'd38);
    check("csrrwi_imm",  qa.out_imm,   32'h5);
    check("csrrwi_we",   qa.out_rd_we, 1'b1);
    step();

    // Asynchronous reset mid-stream
    qa.out_ready = 1'b0;
    push_a(32'h002081B3, 32'h800);
    step();
    qa.in_valid = 1'b0;
    check("pre_arst_valid", qa.out_valid, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", qa.out_valid, 1'b0);
    check("arst_ready", qa.in_ready,  1'b1);
    step();
    rst = 1'b0;
    step();
    check("post_arst_empty", qa.out_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Registered successor to the combinational instruction decoder.
- Accepts fetched RV32I (+ optional CSRRW/CSRRWI) instructions over a valid/ready handshake and decodes each on enqueue into a control-ROM index, register fields, sign-extended immediate, write-enable and illegal flag.
- Holds up to DEPTH decoded entries in a FIFO so fetch and execute decouple.
- Sits between the fetch stage and the execute/control-ROM stage; flushable on branch redirect.

Parameters:
- DEPTH, 2, decoded-entry FIFO depth; legal range 1..16.
- ROM_W, 6, control-ROM index width; must be >= 6, upper bits zero-filled.
- EN_CSR, 1, 1 = decode CSRRW/CSRRWI; 0 = treat opcode 1110011 as illegal.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous discard of all entries.
- in_valid  in  1  instruction offered.
- in_ready  out  1  queue can accept.
- in_instr  in  32  raw instruction.
- in_pc  in  32  instruction address.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer takes head.
- out_code  out  ROM_W  control-ROM index.
- out_pc  out  32  pc of head.
- out_rd, out_rs1, out_rs2  out  5 each  register fields, instr[11:7], [19:15], [24:20].
- out_imm  out  32  sign-extended immediate.
- out_rd_we  out  1  1 for R/I/load/U/J/JALR/CSR when rd != 0; else 0.
- out_illegal  out  1  entry failed decode.

Behaviour:
- Codes:
  - ADD0 SUB1 SLL2 SLT3 SLTU4 XOR5 SRL6 SRA7 OR8 AND9
  - LB10 LH11 LW12 LBU13 LHU14
  - ADDI15 SLLI16 SLTI17 SLTIU18 XORI19 SRLI20 SRAI21 ORI22 ANDI23
  - SB24 SH25 SW26
  - BEQ27 BNE28 BLT29 BGE30 BLTU31 BGEU32
  - AUIPC33 LUI34 JAL35 JALR36
  - CSRRW37 CSRRWI38
  - ILLEGAL = all ones.
- Illegal when any of the following hold; then code = ILLEGAL, out_illegal = 1, out_rd_we = 0, out_imm = 0:
  - instr[1:0] != 11.
  - Unknown opcode.
  - Unused funct3: load 3/6/7; store >= 3; branch 2/3; JALR != 0; CSR not 001/101.
  - R-type funct7 not 0000000, except 0100000 permitted for ADD/SUB and SRL/SRA.
  - SLLI funct7 != 0.
  - SRLI/SRAI funct7 not 0000000/0100000.
  - EN_CSR = 0 with opcode 1110011.
- Immediates:
  - I-type: instr[31:20] sign-extended.
  - S-type: {instr[31:25], instr[11:7]}.
  - B-type: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U-type: {instr[31:12], 12'b0}.
  - J-type: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - Shift-immediates: zero-extended shamt (instr[24:20]).
  - CSRRWI: zero-extended instr[19:15].
  - R-type: 0.
- Handshake:
  - Push when in_valid & in_ready; pop when out_valid & out_ready.
  - in_ready = (count < DEPTH); no combinational dependence on out_ready.
  - Push and pop in the same cycle are both honoured; count is unchanged.
- Latency: an instruction pushed at edge N is visible at the head after edge N if the queue was empty. Decode happens before storage; outputs come straight from the head register.
- Ordering: strict FIFO; circular pointers wrap modulo DEPTH.
- Payload stability: head fields are stable while out_valid & !out_ready. Outputs other than out_valid are don't-care while out_valid = 0.
- Flush: at the next edge count = 0 and pointers = 0. A push in the same cycle is dropped, as is a pop. in_ready in the following cycle = 1.
- Reset: count = 0, pointers = 0, out_valid = 0, in_ready = 1 immediately while rst is asserted. Stored payload registers need no reset. Reset mid-stream discards all entries.
- Full: in_ready = 0; in_valid is ignored.
- Empty: out_valid = 0; out_ready is ignored.

Test Plan:
- Push 0x002081B3 (add x3,x1,x2), pc 0x100, out_ready = 1 → next cycle out_valid = 1, code 0, rd 3, rs1 1, rs2 2, rd_we 1, pc 0x100.
- Push 0xFFC12083 (lw x1,-4(x2)) then 0xFE209EE3 (bne x1,x2,-4) → codes 12 then 28; imm 0xFFFFFFFC for both; bne rd_we 0; order preserved.
- out_ready = 0, DEPTH = 2, push 3 valid instructions → in_ready drops after 2 accepted; the third is held by the source; head is stable; raising out_ready drains in order.
- Push 0x0000007F, 0x00209033 with funct7 0100000 (sll with bad funct7), and 0x0000200F → out_illegal = 1, code 63, rd_we 0 for each.
- Queue holding 2 entries, assert flush together with a push → next cycle out_valid = 0, in_ready = 1; nothing from the flushed or pushed instructions ever appears.
- EN_CSR = 0: push 0x34011073 (csrrw) → illegal. EN_CSR = 1 → code 37, rs1 2. Assert rst asynchronously mid-stream → out_valid falls without a clock edge.
